// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
// Contents: tx_state_t (transmitter FSM states), DEFAULT_CLKS_PER_BIT, UART_DATA_BITS.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 217;
   localparam int UART_DATA_BITS       = 8;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable down-counter marking the last cycle of a bit period
// Ports: clk, rst_n (sync, active-low), load/load_value (start a new period of load_value+1
// cycles), enable (count while high), count (current value), bit_tick (final cycle of period).
module uart_bit_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             bit_tick
);

   // Holds at zero after the final cycle so an un-reloaded timer never wraps mid-bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign bit_tick = enable && (count == '0);

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART serialiser with one-byte holding register
// Ports: clk, rst_n (sync, active-low), tx_data_valid/tx_data/tx_ready (byte handshake),
// tx_serial_data (line, idles high), tx_active (frame in progress), tx_done (last stop cycle).
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_data_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_serial_data,
   output logic       tx_active,
   output logic       tx_done
);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_transmitter: CLKS_PER_BIT must be >= 2");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
      $error("uart_transmitter: STOP_BITS must be 1 or 2");
   end

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT * STOP_BITS);
   localparam logic [CNT_W-1:0]  BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  STOP_LOAD = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  DONE_AT   = CNT_W'(1);
   localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

   tx_state_t        state;
   logic [7:0]       shift_reg;
   logic [7:0]       hold_reg;
   logic             hold_full;
   logic [2:0]       bit_index;
   logic             accept;
   logic             stop_end;
   logic             timer_load;
   logic [CNT_W-1:0] timer_value;
   logic [CNT_W-1:0] timer_count;
   logic             bit_tick;

   // Ready is a pure function of the registered hold flag, so it never depends on valid.
   assign tx_ready = !hold_full;
   assign accept   = tx_data_valid && tx_ready;
   assign stop_end = (state == TX_STOP) && bit_tick;

   // Reload the timer at every bit boundary that leads into another period.
   always_comb begin
      timer_load  = 1'b0;
      timer_value = BIT_LOAD;
      case (state)
         TX_IDLE:  timer_load = accept;
         TX_START: timer_load = bit_tick;
         TX_DATA: begin
            timer_load = bit_tick;
            if (bit_index == LAST_BIT) begin
               timer_value = STOP_LOAD;
            end
         end
         TX_STOP:  timer_load = bit_tick && (hold_full || accept);
         default:  timer_load = 1'b0;
      endcase
   end

   uart_bit_timer #(
      .WIDTH (CNT_W)
   ) u_bit_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (timer_load),
      .load_value (timer_value),
      .enable     (state != TX_IDLE),
      .count      (timer_count),
      .bit_tick   (bit_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= TX_IDLE;
         shift_reg      <= '0;
         hold_reg       <= '0;
         hold_full      <= 1'b0;
         bit_index      <= '0;
         tx_serial_data <= 1'b1;
         tx_active      <= 1'b0;
         tx_done        <= 1'b0;
      end else begin
         // Registered one cycle early so the pulse lands on the final stop cycle.
         tx_done <= (state == TX_STOP) && (timer_count == DONE_AT);

         // Mid-frame bytes park in the holding register; stop_end bytes bypass it.
         if ((state != TX_IDLE) && !stop_end && accept) begin
            hold_reg  <= tx_data;
            hold_full <= 1'b1;
         end

         case (state)
            TX_IDLE: begin
               if (accept) begin
                  shift_reg      <= tx_data;
                  state          <= TX_START;
                  tx_serial_data <= 1'b0;
                  tx_active      <= 1'b1;
               end
            end
            TX_START: begin
               if (bit_tick) begin
                  state          <= TX_DATA;
                  bit_index      <= '0;
                  tx_serial_data <= shift_reg[0];
               end
            end
            TX_DATA: begin
               if (bit_tick) begin
                  if (bit_index == LAST_BIT) begin
                     state          <= TX_STOP;
                     tx_serial_data <= 1'b1;
                  end else begin
                     bit_index      <= bit_index + 3'd1;
                     tx_serial_data <= shift_reg[bit_index + 3'd1];
                  end
               end
            end
            TX_STOP: begin
               if (bit_tick) begin
                  if (hold_full) begin
                     shift_reg      <= hold_reg;
                     hold_full      <= 1'b0;
                     state          <= TX_START;
                     tx_serial_data <= 1'b0;
                  end else if (accept) begin
                     shift_reg      <= tx_data;
                     state          <= TX_START;
                     tx_serial_data <= 1'b0;
                  end else begin
                     state     <= TX_IDLE;
                     tx_active <= 1'b0;
                  end
               end
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
// Instances: dut_a (217 clocks/bit, 1 stop bit), dut_b (4 clocks/bit, 2 stop bits).
module tb_uart_transmitter;

   localparam int CPB_A = 217;
   localparam int F_A   = 10 * CPB_A;
   localparam int CPB_B = 4;
   localparam int SB_B  = 2;
   localparam int F_B   = (10 + SB_B - 1) * CPB_B;
   localparam int MAXC  = 32768;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, valid_a, ready_a, ser_a, act_a, done_a;
   logic [7:0] data_a;
   logic       rst_b, valid_b, ready_b, ser_b, act_b, done_b;
   logic [7:0] data_b;

   uart_transmitter #(.CLKS_PER_BIT(CPB_A), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst_n(rst_a), .tx_data_valid(valid_a), .tx_data(data_a),
      .tx_ready(ready_a), .tx_serial_data(ser_a), .tx_active(act_a), .tx_done(done_a)
   );

   uart_transmitter #(.CLKS_PER_BIT(CPB_B), .STOP_BITS(SB_B)) dut_b (
      .clk(clk), .rst_n(rst_b), .tx_data_valid(valid_b), .tx_data(data_b),
      .tx_ready(ready_b), .tx_serial_data(ser_b), .tx_active(act_b), .tx_done(done_b)
   );

   // cyc = number of rising edges so far; history[c] = output value in the cycle after edge c.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic line_a_h [MAXC];
   logic done_a_h [MAXC];
   logic act_a_h  [MAXC];
   logic rdy_a_h  [MAXC];
   logic line_b_h [MAXC];
   logic done_b_h [MAXC];
   logic act_b_h  [MAXC];

   always @(negedge clk) begin
      if (cyc < MAXC) begin
         line_a_h[cyc] = ser_a;
         done_a_h[cyc] = done_a;
         act_a_h[cyc]  = act_a;
         rdy_a_h[cyc]  = ready_a;
         line_b_h[cyc] = ser_b;
         done_b_h[cyc] = done_b;
         act_b_h[cyc]  = act_b;
      end
   end

   int checks   = 0;
   int failures = 0;

   // Reference: line level k cycles into an 8N1 frame (start, 8 data LSB first, stop high).
   function automatic logic exp_level(input logic [7:0] b, input int k, input int cpb);
      int slot;
      slot = k / cpb;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   function automatic int frame_errs_a(input logic [7:0] b, input int s);
      int n = 0;
      for (int k = 0; k < F_A; k++)
         if (line_a_h[s+k] !== exp_level(b, k, CPB_A)) n++;
      return n;
   endfunction

   function automatic int done_count_a(input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++)
         if (done_a_h[c] === 1'b1) n++;
      return n;
   endfunction

   function automatic int max2(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   // Called at a negedge; returns at a negedge with e = accepting edge number.
   task automatic put_a(input logic [7:0] d, output int e);
      valid_a = 1'b1;
      data_a  = d;
      e       = -1;
      for (int i = 0; i < 8000; i++) begin
         if (ready_a === 1'b1) begin
            e = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      if (e < 0) begin
         checks++;
         failures++;
         $display("FAIL put_a_timeout data=%h ready=%b required=1", d, ready_a);
      end else begin
         @(negedge clk);
      end
      valid_a = 1'b0;
      data_a  = 8'($urandom);
   endtask

   task automatic put_b(input logic [7:0] d, output int e);
      valid_b = 1'b1;
      data_b  = d;
      e       = -1;
      for (int i = 0; i < 2000; i++) begin
         if (ready_b === 1'b1) begin
            e = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      if (e < 0) begin
         checks++;
         failures++;
         $display("FAIL put_b_timeout data=%h ready=%b required=1", d, ready_b);
      end else begin
         @(negedge clk);
      end
      valid_b = 1'b0;
      data_b  = 8'($urandom);
   endtask

   task automatic test_reset();
      rst_a = 1'b0; rst_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
      data_a = 8'h00; data_b = 8'h00;
      repeat (3) @(negedge clk);
      checks++; if (ser_a !== 1'b1)   begin failures++; $display("FAIL reset_line_a got=%b exp=1", ser_a); end
      checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready_a got=%b exp=1", ready_a); end
      checks++; if (act_a !== 1'b0)   begin failures++; $display("FAIL reset_active_a got=%b exp=0", act_a); end
      checks++; if (done_a !== 1'b0)  begin failures++; $display("FAIL reset_done_a got=%b exp=0", done_a); end
      checks++; if (ser_b !== 1'b1)   begin failures++; $display("FAIL reset_line_b got=%b exp=1", ser_b); end
      checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL reset_ready_b got=%b exp=1", ready_b); end
      checks++; if (act_b !== 1'b0)   begin failures++; $display("FAIL reset_active_b got=%b exp=0", act_b); end
      checks++; if (done_b !== 1'b0)  begin failures++; $display("FAIL reset_done_b got=%b exp=0", done_b); end
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_byte();
      int e, n;
      put_a(8'hA5, e);
      repeat (F_A + 4) @(negedge clk);
      checks++; if (line_a_h[e-1] !== 1'b1) begin failures++; $display("FAIL single_idle_before got=%b exp=1", line_a_h[e-1]); end
      n = frame_errs_a(8'hA5, e);
      checks++; if (n != 0) begin failures++; $display("FAIL single_frame_A5 bad_cycles=%0d exp=0", n); end
      checks++; if (rdy_a_h[e] !== 1'b1) begin failures++; $display("FAIL single_ready_after_idle_accept got=%b exp=1", rdy_a_h[e]); end
      checks++; if (act_a_h[e] !== 1'b1) begin failures++; $display("FAIL single_active_start got=%b exp=1", act_a_h[e]); end
      checks++; if (done_a_h[e+F_A-1] !== 1'b1) begin failures++; $display("FAIL single_done_at_2170 got=%b exp=1", done_a_h[e+F_A-1]); end
      n = done_count_a(e - 1, e + F_A + 3);
      checks++; if (n != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", n); end
      checks++; if (act_a_h[e+F_A] !== 1'b0) begin failures++; $display("FAIL single_active_after got=%b exp=0", act_a_h[e+F_A]); end
      checks++; if (line_a_h[e+F_A] !== 1'b1) begin failures++; $display("FAIL single_line_after got=%b exp=1", line_a_h[e+F_A]); end
   endtask

   task automatic test_back_to_back();
      int e1, e2, s1, s2, n, gaps;
      put_a(8'h00, e1);
      put_a(8'hFF, e2);
      s1 = e1;
      s2 = max2(e2, s1 + F_A);
      repeat (2 * F_A + 4) @(negedge clk);
      n = frame_errs_a(8'h00, s1);
      checks++; if (n != 0) begin failures++; $display("FAIL b2b_frame_00 bad_cycles=%0d exp=0", n); end
      n = frame_errs_a(8'hFF, s2);
      checks++; if (n != 0) begin failures++; $display("FAIL b2b_frame_FF bad_cycles=%0d exp=0", n); end
      gaps = 0;
      for (int c = s1; c < s2 + F_A; c++) if (act_a_h[c] !== 1'b1) gaps++;
      checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_idle_gap inactive_cycles=%0d exp=0", gaps); end
      checks++; if (done_a_h[s1+F_A-1] !== 1'b1 || done_a_h[s2+F_A-1] !== 1'b1) begin
         failures++; $display("FAIL b2b_done_spacing got=%b,%b exp=1,1", done_a_h[s1+F_A-1], done_a_h[s2+F_A-1]);
      end
      n = done_count_a(s1, s2 + F_A + 3);
      checks++; if (n != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", n); end
   endtask

   task automatic test_backpressure();
      int e1, e2, e3, s1, s2, s3, n;
      put_a(8'h11, e1);
      put_a(8'h22, e2);
      put_a(8'h33, e3);
      s1 = e1;
      s2 = max2(e2, s1 + F_A);
      s3 = max2(e3, s2 + F_A);
      repeat (s3 + F_A + 4 - cyc) @(negedge clk);
      checks++; if (rdy_a_h[e2] !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", rdy_a_h[e2]); end
      // Holding register drains at the end of the first stop bit; ready is back one cycle later.
      checks++; if (e3 != s1 + F_A + 1) begin failures++; $display("FAIL bp_accept_33_edge got=%0d exp=%0d", e3 - s1, F_A + 1); end
      n = frame_errs_a(8'h11, s1);
      checks++; if (n != 0) begin failures++; $display("FAIL bp_frame_11 bad_cycles=%0d exp=0", n); end
      n = frame_errs_a(8'h22, s2);
      checks++; if (n != 0) begin failures++; $display("FAIL bp_frame_22 bad_cycles=%0d exp=0", n); end
      n = frame_errs_a(8'h33, s3);
      checks++; if (n != 0) begin failures++; $display("FAIL bp_frame_33 bad_cycles=%0d exp=0", n); end
      n = done_count_a(s1, s3 + F_A + 3);
      checks++; if (n != 3) begin failures++; $display("FAIL bp_done_count got=%0d exp=3", n); end
   endtask

   task automatic test_reset_mid_frame();
      int e, e2, r, n, e3;
      put_a(8'h5A, e);
      put_a(8'h99, e2);
      while (cyc < e + 4 * CPB_A + 100) @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      r = cyc;
      checks++; if (ser_a !== 1'b1)   begin failures++; $display("FAIL midrst_line got=%b exp=1", ser_a); end
      checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready_a); end
      checks++; if (act_a !== 1'b0)   begin failures++; $display("FAIL midrst_active got=%b exp=0", act_a); end
      checks++; if (done_a !== 1'b0)  begin failures++; $display("FAIL midrst_done got=%b exp=0", done_a); end
      rst_a = 1'b1;
      repeat (F_A + 2) @(negedge clk);
      n = 0;
      for (int c = r; c < r + F_A; c++) if (line_a_h[c] !== 1'b1 || done_a_h[c] !== 1'b0) n++;
      checks++; if (n != 0) begin failures++; $display("FAIL midrst_quiet_after bad_cycles=%0d exp=0", n); end
      put_a(8'hC3, e3);
      repeat (F_A + 4) @(negedge clk);
      n = frame_errs_a(8'hC3, e3);
      checks++; if (n != 0) begin failures++; $display("FAIL midrst_frame_C3 bad_cycles=%0d exp=0", n); end
      checks++; if (done_a_h[e3+F_A-1] !== 1'b1) begin failures++; $display("FAIL midrst_done_C3 got=%b exp=1", done_a_h[e3+F_A-1]); end
   endtask

   task automatic test_two_stop_bits();
      int e, n;
      put_b(8'h80, e);
      repeat (F_B + 4) @(negedge clk);
      n = 0;
      for (int k = 0; k < F_B; k++) if (line_b_h[e+k] !== exp_level(8'h80, k, CPB_B)) n++;
      checks++; if (n != 0) begin failures++; $display("FAIL two_stop_frame_80 bad_cycles=%0d exp=0", n); end
      checks++; if (done_b_h[e+F_B-1] !== 1'b1) begin failures++; $display("FAIL two_stop_done_at_44 got=%b exp=1", done_b_h[e+F_B-1]); end
      n = 0;
      for (int c = e; c < e + F_B + 3; c++) if (done_b_h[c] === 1'b1) n++;
      checks++; if (n != 1) begin failures++; $display("FAIL two_stop_done_count got=%0d exp=1", n); end
      checks++; if (act_b_h[e+F_B-1] !== 1'b1 || act_b_h[e+F_B] !== 1'b0) begin
         failures++; $display("FAIL two_stop_active_edge got=%b%b exp=10", act_b_h[e+F_B-1], act_b_h[e+F_B]);
      end
   endtask

   task automatic test_random_stream();
      localparam int NB = 24;
      logic [7:0] bytes [NB];
      int         edges [NB];
      int         starts [NB];
      int         lo, hi, nl, nd;
      logic       exp_line, exp_done;
      lo = cyc + 1;
      for (int i = 0; i < NB; i++) begin
         bytes[i] = 8'($urandom);
         repeat ($urandom_range(0, 60)) @(negedge clk);
         put_b(bytes[i], edges[i]);
      end
      for (int i = 0; i < NB; i++)
         starts[i] = (i == 0) ? edges[0] : max2(edges[i], starts[i-1] + F_B);
      hi = starts[NB-1] + F_B + 8;
      while (cyc < hi + 2) @(negedge clk);
      nl = 0;
      nd = 0;
      for (int c = lo; c <= hi; c++) begin
         exp_line = 1'b1;
         exp_done = 1'b0;
         for (int i = 0; i < NB; i++) begin
            if (c >= starts[i] && c < starts[i] + F_B) exp_line = exp_level(bytes[i], c - starts[i], CPB_B);
            if (c == starts[i] + F_B - 1) exp_done = 1'b1;
         end
         if (line_b_h[c] !== exp_line) nl++;
         if (done_b_h[c] !== exp_done) nd++;
      end
      checks++; if (nl != 0) begin failures++; $display("FAIL random_line bad_cycles=%0d exp=0", nl); end
      checks++; if (nd != 0) begin failures++; $display("FAIL random_done bad_cycles=%0d exp=0", nd); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_frame();
      test_two_stop_bits();
      test_random_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
